// File: rtl/main_mem_controller_pkg.sv
// Shared definitions for the main memory controller slice.
// Contents: line geometry, word-select field position, latency counter
// width and the controller state enum.
package main_mem_controller_pkg;

  localparam int LINE_BYTES    = 128;
  localparam int LINE_BITS     = LINE_BYTES * 8;
  localparam int LINE_OFFSET_W = 7;   // addr[6:0] is the byte offset inside a line
  localparam int WORD_SEL_LSB  = 2;   // word select is addr[6:2]
  localparam int WORD_SEL_W    = 5;
  localparam int CNT_W         = 4;   // holds READ_LATENCY-1 for latencies up to 15

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    MISS_REQ,
    MISS_WAIT,
    WR_MERGE
  } mc_state_t;

endpackage

// File: rtl/mc_line_store.sv
// Byte-maskable line store with per-line valid bits.
// Ports:
//   clk, rst                 clock and async active-high reset (clears valid bits only)
//   we, w_line, w_data,      one masked line write per cycle; a write also marks
//   w_mask                   the line valid
//   chk_a_line/chk_a_valid   two independent valid-bit lookups
//   chk_b_line/chk_b_valid
//   rd_line, rd_sel, rd_data combinational 32-bit word read
module mc_line_store
  import main_mem_controller_pkg::*;
#(
  parameter int MEM_LINES = 256,
  localparam int IDX_W    = $clog2(MEM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      w_line,
  input  logic [LINE_BITS-1:0]  w_data,
  input  logic [LINE_BYTES-1:0] w_mask,
  input  logic [IDX_W-1:0]      chk_a_line,
  output logic                  chk_a_valid,
  input  logic [IDX_W-1:0]      chk_b_line,
  output logic                  chk_b_valid,
  input  logic [IDX_W-1:0]      rd_line,
  input  logic [WORD_SEL_W-1:0] rd_sel,
  output logic [31:0]           rd_data
);

  logic [LINE_BITS-1:0] mem [MEM_LINES];
  logic [MEM_LINES-1:0] valid_bits;

  // Data array has no reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (we && w_mask[b]) begin
        mem[w_line][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Valid bits are cleared by reset and set by any committed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (we) begin
      valid_bits[w_line] <= 1'b1;
    end
  end

  assign chk_a_valid = valid_bits[chk_a_line];
  assign chk_b_valid = valid_bits[chk_b_line];
  assign rd_data     = mem[rd_line][{rd_sel, 5'b00000} +: 32];

endmodule

// File: rtl/main_mem_controller.sv
// Memory-side controller: fixed-latency word reads and byte-masked line
// writes against mc_line_store, with repair escalation to the arbiter for
// accesses that touch an invalid line.
// Ports:
//   clk, rst                         clock, async active-high reset
//   raddr_valid, raddr               1-cycle read request, byte address
//   waddr_valid, waddr, wdata, wmask 1-cycle line write request
//   sent_repair, repair_resolved     arbiter handshake for repair requests
//   rdata, rdata_valid               read result and its 1-cycle strobe
//   read_repair_request,             level repair requests (never both high)
//   write_miss_repair, missed_addr   and the address being repaired
module main_mem_controller
  import main_mem_controller_pkg::*;
#(
  parameter int MEM_LINES    = 256,
  parameter int READ_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  raddr_valid,
  input  logic [31:0]           raddr,
  input  logic                  waddr_valid,
  input  logic [31:0]           waddr,
  input  logic [LINE_BITS-1:0]  wdata,
  input  logic [LINE_BYTES-1:0] wmask,
  input  logic                  sent_repair,
  input  logic                  repair_resolved,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  read_repair_request,
  output logic                  write_miss_repair,
  output logic [31:0]           missed_addr
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(READ_LATENCY - 1);

  mc_state_t             state;
  logic [CNT_W-1:0]      counter;
  logic [31:0]           pend_addr;
  logic [LINE_BITS-1:0]  pend_data;
  logic [LINE_BYTES-1:0] pend_mask;
  logic                  pend_write;

  logic [IDX_W-1:0]      r_line, w_line, p_line, chk_line, st_line;
  logic                  w_line_valid, chk_line_valid, chk_valid, w_hit;
  logic                  write_now, write_miss, read_take, st_we, drop_event;
  logic [LINE_BITS-1:0]  st_data;
  logic [LINE_BYTES-1:0] st_mask;
  logic [31:0]           rd_word;
  logic                  unused_addr_bits;

  assign r_line = raddr[LINE_OFFSET_W +: IDX_W];
  assign w_line = waddr[LINE_OFFSET_W +: IDX_W];
  assign p_line = pend_addr[LINE_OFFSET_W +: IDX_W];

  // Word offsets below bit 2 and the aliased upper address bits are not decoded.
  assign unused_addr_bits = ^{raddr[1:0], raddr[31:LINE_OFFSET_W+IDX_W],
                              waddr[LINE_OFFSET_W-1:0], waddr[31:LINE_OFFSET_W+IDX_W],
                              pend_addr[1:0], pend_addr[31:LINE_OFFSET_W+IDX_W]};

  // A write can commit directly when its line is valid or it overwrites every byte.
  assign w_hit = w_line_valid | (&wmask);

  // Decide what happens to an incoming write in the current state. While a
  // repair is outstanding, writes that could commit directly are the fills;
  // a partial write to an invalid line cannot start a second miss and is dropped.
  always_comb begin
    write_now  = 1'b0;
    write_miss = 1'b0;
    if (waddr_valid) begin
      case (state)
        IDLE: begin
          write_now  = w_hit;
          write_miss = !w_hit;
        end
        MISS_REQ, MISS_WAIT: write_now = w_hit;
        default: ;
      endcase
    end
  end

  // A read is only taken in IDLE, and a write miss starting in the same cycle wins.
  assign read_take = raddr_valid && (state == IDLE) && !write_miss;

  // Hit check sees a write committing at the same edge to the same line.
  assign chk_line  = (state == IDLE) ? r_line : p_line;
  assign chk_valid = chk_line_valid | (write_now && (w_line == chk_line));

  assign st_we   = write_now | (state == WR_MERGE);
  assign st_line = (state == WR_MERGE) ? p_line    : w_line;
  assign st_data = (state == WR_MERGE) ? pend_data : wdata;
  assign st_mask = (state == WR_MERGE) ? pend_mask : wmask;

  mc_line_store #(.MEM_LINES(MEM_LINES)) u_store (
    .clk         (clk),
    .rst         (rst),
    .we          (st_we),
    .w_line      (st_line),
    .w_data      (st_data),
    .w_mask      (st_mask),
    .chk_a_line  (w_line),
    .chk_a_valid (w_line_valid),
    .chk_b_line  (chk_line),
    .chk_b_valid (chk_line_valid),
    .rd_line     (p_line),
    .rd_sel      (pend_addr[WORD_SEL_LSB +: WORD_SEL_W]),
    .rd_data     (rd_word)
  );

  // Controller FSM with all outputs registered. rdata is sampled from the
  // store on the edge that ends the latency count, so it reflects any
  // write committed before that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      counter             <= '0;
      pend_addr           <= '0;
      pend_data           <= '0;
      pend_mask           <= '0;
      pend_write          <= 1'b0;
      rdata               <= '0;
      rdata_valid         <= 1'b0;
      read_repair_request <= 1'b0;
      write_miss_repair   <= 1'b0;
      missed_addr         <= '0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (write_miss) begin
            pend_addr         <= waddr;
            pend_data         <= wdata;
            pend_mask         <= wmask;
            pend_write        <= 1'b1;
            missed_addr       <= waddr;
            write_miss_repair <= 1'b1;
            state             <= MISS_REQ;
          end else if (read_take) begin
            pend_addr  <= raddr;
            pend_write <= 1'b0;
            if (chk_valid) begin
              counter <= CNT_RELOAD;
              state   <= RD_WAIT;
            end else begin
              missed_addr         <= raddr;
              read_repair_request <= 1'b1;
              state               <= MISS_REQ;
            end
          end
        end
        RD_WAIT: begin
          if (counter == '0) begin
            rdata       <= rd_word;
            rdata_valid <= 1'b1;
            state       <= IDLE;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        MISS_REQ: begin
          if (sent_repair) begin
            read_repair_request <= 1'b0;
            write_miss_repair   <= 1'b0;
            state               <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (repair_resolved) begin
            if (pend_write) begin
              state <= WR_MERGE;
            end else if (chk_valid) begin
              counter <= CNT_RELOAD;
              state   <= RD_WAIT;
            end else begin
              read_repair_request <= 1'b1;
              state               <= MISS_REQ;
            end
          end
        end
        WR_MERGE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Any request that arrives while it cannot be served is silently lost;
  // the arbiter is expected to keep a single access outstanding.
  assign drop_event = (raddr_valid && !read_take) ||
                      (waddr_valid && !write_now && !write_miss);

  drop_seen: cover property (@(posedge clk) disable iff (rst) drop_event);

  req_exclusive: assert property (@(posedge clk) disable iff (rst)
                                  !(read_repair_request && write_miss_repair));

endmodule
